// File: rtl/write_responder_pkg.sv
// Shared types and constants for the write-back store responder.
//   regval_t         : 32-bit register/bus value
//   WriteBufferDepth : default number of posted stores held
//   wb_entry_t       : one buffered store {address, data}
package write_responder_pkg;

    typedef logic [31:0] regval_t;

    localparam int unsigned WriteBufferDepth = 4;

    typedef struct packed {
        regval_t address;
        regval_t data;
    } wb_entry_t;

endpackage

// File: rtl/write_responder_if.sv
// Bundle of the store request port, data-memory bus and snoop port.
//   store port : address_enable, address, data -> data_valid
//   memory bus : mem_write, mem_address, mem_data <- mem_waitrequest
//   snoop port : snoop_address -> snoop_hit, snoop_data
//   status     : pending, empty
// slave modport is the responder side, master the requester/memory side.
interface write_responder_if
    import write_responder_pkg::*;
#(
    parameter int unsigned DEPTH = WriteBufferDepth
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic            address_enable;
    regval_t         address;
    regval_t         data;
    logic            data_valid;

    logic            mem_write;
    regval_t         mem_address;
    regval_t         mem_data;
    logic            mem_waitrequest;

    regval_t         snoop_address;
    logic            snoop_hit;
    regval_t         snoop_data;

    logic [PTR_W:0]  pending;
    logic            empty;

    modport slave (
        input  address_enable, address, data, mem_waitrequest, snoop_address,
        output data_valid, mem_write, mem_address, mem_data, snoop_hit, snoop_data,
        pending, empty
    );

    modport master (
        output address_enable, address, data, mem_waitrequest, snoop_address,
        input  data_valid, mem_write, mem_address, mem_data, snoop_hit, snoop_data,
        pending, empty
    );

endinterface

// File: rtl/write_responder_write_buffer_fifo.sv
// In-order posted-write buffer with associative snoop.
//   clock, reset_n : system clock, synchronous active-low reset
//   push/push_entry: append an entry at tail (caller guarantees not full)
//   pop            : retire the head entry (caller guarantees not empty)
//   head_entry     : oldest buffered entry
//   count          : number of valid entries (0..DEPTH)
//   snoop_*        : youngest valid entry whose address matches exactly
module write_buffer_fifo
    import write_responder_pkg::*;
#(
    parameter int unsigned DEPTH = WriteBufferDepth,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic           clock,
    input  logic           reset_n,
    input  logic           push,
    input  wb_entry_t      push_entry,
    input  logic           pop,
    output wb_entry_t      head_entry,
    output logic [PTR_W:0] count,
    input  regval_t        snoop_address,
    output logic           snoop_hit,
    output regval_t        snoop_data
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("write_buffer_fifo: DEPTH must be a power of two >= 2");
    end

    wb_entry_t        entries_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;

    // Pointers wrap naturally at PTR_W bits; full vs empty is told apart by count.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push) begin
            tail_d = tail_q + 1'b1;
        end
        if (pop) begin
            head_d = head_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage is deliberately not reset; validity is tracked by count.
    always_ff @(posedge clock) begin
        if (push) begin
            entries_q[tail_q] <= push_entry;
        end
    end

    assign head_entry = entries_q[head_q];
    assign count      = count_q;

    // Walk from oldest to youngest so a later match overrides an earlier one.
    always_comb begin
        logic [PTR_W-1:0] idx;
        snoop_hit  = 1'b0;
        snoop_data = '0;
        idx        = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head_q + PTR_W'(i);
            if (((PTR_W + 1)'(i) < count_q) && (entries_q[idx].address == snoop_address)) begin
                snoop_hit  = 1'b1;
                snoop_data = entries_q[idx].data;
            end
        end
    end

endmodule

// File: rtl/write_responder.sv
// Memory-side responder for the write-back store port.
//   clock, reset_n : system clock, synchronous active-low reset
//   bus (slave)    : store request/accept, Avalon-style write drain,
//                    combinational snoop, occupancy status
// Accepted stores are posted into write_buffer_fifo and drained in order.
module write_responder
    import write_responder_pkg::*;
#(
    parameter int unsigned DEPTH = WriteBufferDepth
) (
    input  logic                clock,
    input  logic                reset_n,
    write_responder_if.slave    bus
);

    localparam int unsigned    PTR_W     = $clog2(DEPTH);
    localparam logic [PTR_W:0] FullCount = (PTR_W + 1)'(DEPTH);

    logic           push;
    logic           pop;
    wb_entry_t      push_entry;
    wb_entry_t      head_entry;
    logic [PTR_W:0] count;
    logic           fifo_hit;
    regval_t        fifo_snoop_data;

    // Acceptance looks only at the registered count, so a full buffer refuses
    // even when the head retires this cycle and mem_waitrequest never reaches
    // data_valid combinationally.
    always_comb begin
        push               = reset_n && bus.address_enable && (count != FullCount);
        push_entry.address = bus.address;
        push_entry.data    = bus.data;

        bus.data_valid     = push;
        bus.mem_write      = reset_n && (count != '0);
        bus.mem_address    = head_entry.address;
        bus.mem_data       = head_entry.data;
        pop                = bus.mem_write && !bus.mem_waitrequest;

        bus.snoop_hit      = reset_n && fifo_hit;
        bus.snoop_data     = bus.snoop_hit ? fifo_snoop_data : '0;

        bus.pending        = count;
        bus.empty          = (count == '0);
    end

    write_buffer_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock         (clock),
        .reset_n       (reset_n),
        .push          (push),
        .push_entry    (push_entry),
        .pop           (pop),
        .head_entry    (head_entry),
        .count         (count),
        .snoop_address (bus.snoop_address),
        .snoop_hit     (fifo_hit),
        .snoop_data    (fifo_snoop_data)
    );

endmodule

// File: tb/tb_write_responder.sv
// Directed bench for write_responder: stimulus pushes the expected bus
// writes into a queue, an independent monitor pops and compares on retire.
module tb_write_responder;
    import write_responder_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic clock = 1'b0;
    logic reset_n;

    write_responder_if #(.DEPTH(DEPTH)) bus ();

    write_responder #(
        .DEPTH (DEPTH)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    int        n_cmp = 0;
    int        n_err = 0;
    wb_entry_t exp_q[$];
    int        waits;
    bit        toggling;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called just after a posedge; returns just after the accepting posedge.
    task automatic store(input regval_t a, input regval_t d, output int nwait);
        bus.address_enable = 1'b1;
        bus.address        = a;
        bus.data           = d;
        exp_q.push_back('{address: a, data: d});
        nwait = 0;
        forever begin
            @(negedge clock);
            if (bus.data_valid) break;
            nwait++;
            if (nwait > 40) begin
                check("store_timeout", 32'(nwait), 32'd0);
                break;
            end
            @(posedge clock);
            #1;
        end
        @(posedge clock);
        #1;
        bus.address_enable = 1'b0;
    endtask

    task automatic wait_empty();
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (bus.empty) begin
                @(posedge clock);
                #1;
                return;
            end
        end
        check("drain_timeout", 32'(bus.pending), 32'd0);
        @(posedge clock);
        #1;
    endtask

    // Scoreboard monitor: every retiring bus write must match the oldest expectation.
    initial begin
        wb_entry_t e;
        forever begin
            @(negedge clock);
            if (bus.mem_write && !bus.mem_waitrequest) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_write: got addr %h data %h expected no write",
                             bus.mem_address, bus.mem_data);
                end else begin
                    e = exp_q.pop_front();
                    check("bus_addr", bus.mem_address, e.address);
                    check("bus_data", bus.mem_data, e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n             = 1'b0;
        bus.address_enable  = 1'b0;
        bus.address         = '0;
        bus.data            = '0;
        bus.mem_waitrequest = 1'b0;
        bus.snoop_address   = '0;
        toggling            = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;

        // Reset state
        @(negedge clock);
        check("rst_data_valid", 32'(bus.data_valid), 32'd0);
        check("rst_mem_write", 32'(bus.mem_write), 32'd0);
        check("rst_snoop_hit", 32'(bus.snoop_hit), 32'd0);
        check("rst_snoop_data", bus.snoop_data, 32'd0);
        check("rst_pending", 32'(bus.pending), 32'd0);
        check("rst_empty", 32'(bus.empty), 32'd1);
        @(posedge clock);
        #1;

        // 1. Single store, one-cycle latency to the bus
        store(32'h100, 32'hDEADBEEF, waits);
        check("t1_accept_now", 32'(waits), 32'd0);
        @(negedge clock);
        check("t1_mem_write", 32'(bus.mem_write), 32'd1);
        check("t1_mem_address", bus.mem_address, 32'h100);
        check("t1_mem_data", bus.mem_data, 32'hDEADBEEF);
        @(negedge clock);
        check("t1_empty", 32'(bus.empty), 32'd1);
        @(posedge clock);
        #1;

        // 2. Fill under stall, fifth store waits until a slot frees
        bus.mem_waitrequest = 1'b1;
        store(32'h10, 32'h0000_1010, waits);
        check("t2_accept0", 32'(waits), 32'd0);
        store(32'h14, 32'h0000_1014, waits);
        check("t2_accept1", 32'(waits), 32'd0);
        store(32'h18, 32'h0000_1018, waits);
        check("t2_accept2", 32'(waits), 32'd0);
        store(32'h1C, 32'h0000_101C, waits);
        check("t2_accept3", 32'(waits), 32'd0);
        bus.address_enable = 1'b1;
        bus.address        = 32'h20;
        bus.data           = 32'h0000_1020;
        exp_q.push_back('{address: 32'h20, data: 32'h0000_1020});
        @(negedge clock);
        check("t2_full_refuse", 32'(bus.data_valid), 32'd0);
        check("t2_full_pending", 32'(bus.pending), 32'd4);
        @(posedge clock);
        #1;
        bus.mem_waitrequest = 1'b0;
        @(negedge clock);
        check("t2_refuse_while_pop", 32'(bus.data_valid), 32'd0);
        @(posedge clock);
        #1;
        @(negedge clock);
        check("t2_accept_after_pop", 32'(bus.data_valid), 32'd1);
        @(posedge clock);
        #1;
        bus.address_enable = 1'b0;
        wait_empty();

        // 3. Head held stable through a 3-cycle stall
        bus.mem_waitrequest = 1'b1;
        store(32'h40, 32'hCAFEF00D, waits);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("t3_hold_write", 32'(bus.mem_write), 32'd1);
            check("t3_hold_addr", bus.mem_address, 32'h40);
            check("t3_hold_data", bus.mem_data, 32'hCAFEF00D);
            @(posedge clock);
            #1;
        end
        bus.mem_waitrequest = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check("t3_retired", 32'(bus.empty), 32'd1);
        @(posedge clock);
        #1;

        // 4. Snoop returns the youngest match, not the in-flight request
        bus.mem_waitrequest = 1'b1;
        store(32'h80, 32'h1, waits);
        store(32'h84, 32'h2, waits);
        store(32'h80, 32'h3, waits);
        bus.snoop_address = 32'h80;
        @(negedge clock);
        check("t4_hit80", 32'(bus.snoop_hit), 32'd1);
        check("t4_data80", bus.snoop_data, 32'h3);
        @(posedge clock);
        #1;
        bus.snoop_address = 32'h84;
        @(negedge clock);
        check("t4_data84", bus.snoop_data, 32'h2);
        @(posedge clock);
        #1;
        bus.snoop_address = 32'h88;
        @(negedge clock);
        check("t4_miss_hit", 32'(bus.snoop_hit), 32'd0);
        check("t4_miss_data", bus.snoop_data, 32'h0);
        @(posedge clock);
        #1;
        bus.snoop_address  = 32'h90;
        bus.address_enable = 1'b1;
        bus.address        = 32'h90;
        bus.data           = 32'h4;
        exp_q.push_back('{address: 32'h90, data: 32'h4});
        @(negedge clock);
        check("t4_same_cycle_dv", 32'(bus.data_valid), 32'd1);
        check("t4_same_cycle_nohit", 32'(bus.snoop_hit), 32'd0);
        @(posedge clock);
        #1;
        bus.address_enable = 1'b0;
        @(negedge clock);
        check("t4_next_cycle_hit", 32'(bus.snoop_hit), 32'd1);
        check("t4_next_cycle_data", bus.snoop_data, 32'h4);
        @(posedge clock);
        #1;
        bus.mem_waitrequest = 1'b0;
        wait_empty();

        // 5. Ten stores while waitrequest toggles every cycle
        toggling = 1'b1;
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    store(32'h200 + 32'(4 * i), 32'h5000 + 32'(i), waits);
                end
                toggling = 1'b0;
            end
            begin
                while (toggling) begin
                    @(negedge clock);
                    check("t5_pending_le_depth", 32'(bus.pending <= 3'(DEPTH)), 32'd1);
                    @(posedge clock);
                    #1;
                    bus.mem_waitrequest = ~bus.mem_waitrequest;
                end
            end
        join
        bus.mem_waitrequest = 1'b0;
        wait_empty();

        // 6. Reset while stores are buffered discards them
        bus.mem_waitrequest = 1'b1;
        store(32'h300, 32'hA0, waits);
        store(32'h304, 32'hA1, waits);
        store(32'h308, 32'hA2, waits);
        @(negedge clock);
        check("t6_pending3", 32'(bus.pending), 32'd3);
        check("t6_mem_write", 32'(bus.mem_write), 32'd1);
        @(posedge clock);
        #1;
        reset_n            = 1'b0;
        bus.address_enable = 1'b1;
        bus.address        = 32'h3FC;
        bus.data           = 32'hBAD;
        bus.snoop_address  = 32'h300;
        @(negedge clock);
        check("t6_rst_mem_write", 32'(bus.mem_write), 32'd0);
        check("t6_rst_data_valid", 32'(bus.data_valid), 32'd0);
        check("t6_rst_snoop_hit", 32'(bus.snoop_hit), 32'd0);
        exp_q.delete();
        @(posedge clock);
        #1;
        reset_n             = 1'b1;
        bus.address_enable  = 1'b0;
        bus.mem_waitrequest = 1'b0;
        @(negedge clock);
        check("t6_post_pending", 32'(bus.pending), 32'd0);
        check("t6_post_empty", 32'(bus.empty), 32'd1);
        check("t6_post_mem_write", 32'(bus.mem_write), 32'd0);
        @(posedge clock);
        #1;
        repeat (5) @(posedge clock);
        #1;
        store(32'h400, 32'h12345678, waits);
        check("t6_restart_accept", 32'(waits), 32'd0);
        wait_empty();

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
